store_buffer_stage: RTL and testbench

//  Parametrised committed-store buffer between the ALU stage and data_cache. Stores

---
 rtl/store_buffer_stage_if.sv | 47 ++++
 rtl/store_buffer_stage.sv | 132 +++++++++++++
 tb/tb_store_buffer_stage.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_stage_if.sv
// Purpose: bundles the request, forwarding, drain and fence signals of the
// committed-store buffer into one interface.
//   slave  : the buffer itself (consumes requests and drain_ready, produces the rest)
//   master : the ALU stage / data_cache side (or a testbench)
// Signals: req_* (request from ALU), fwd_* (load forwarding), drain_* (head entry
// offered to data_cache), fence_req/fence_done, sb_count/sb_empty (occupancy).
interface store_buffer_stage_if #(
  parameter int SB_ENTRIES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = $clog2(SB_ENTRIES) + 1;

  logic                  req_valid;
  logic                  req_is_store;
  logic                  req_size_byte;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_ready;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  drain_valid;
  logic [ADDR_WIDTH-1:0] drain_addr;
  logic [DATA_WIDTH-1:0] drain_data;
  logic                  drain_size_byte;
  logic                  drain_ready;
  logic                  fence_req;
  logic                  fence_done;
  logic [CW-1:0]         sb_count;
  logic                  sb_empty;

  modport slave (
    input  req_valid, req_is_store, req_size_byte, req_addr, req_data,
    output req_ready, fwd_hit, fwd_data,
    output drain_valid, drain_addr, drain_data, drain_size_byte,
    input  drain_ready, fence_req,
    output fence_done, sb_count, sb_empty
  );

  modport master (
    output req_valid, req_is_store, req_size_byte, req_addr, req_data,
    input  req_ready, fwd_hit, fwd_data,
    input  drain_valid, drain_addr, drain_data, drain_size_byte,
    output drain_ready, fence_req,
    input  fence_done, sb_count, sb_empty
  );
endinterface

// File: rtl/store_buffer_stage.sv
// Purpose: committed-store buffer between the ALU stage and data_cache. Stores
// retire into a FIFO that drains to the cache whenever it is ready; loads search
// the buffer youngest-first and are either forwarded (full coverage), passed on
// to the cache (no match) or stalled (partial overlap). A fence drains the
// buffer to empty and then pulses fence_done.
// Ports:
//   clock  - single clock domain
//   reset  - asynchronous, active-low
//   sb     - store_buffer_stage_if.slave (request, forward, drain, fence, occupancy)
module store_buffer_stage #(
  parameter int SB_ENTRIES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  store_buffer_stage_if.slave  sb
);
  localparam int PW = $clog2(SB_ENTRIES);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_RUN, S_FENCE, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr [SB_ENTRIES];
  logic [DATA_WIDTH-1:0] r_data [SB_ENTRIES];
  logic [SB_ENTRIES-1:0] r_byte;

  // Pointers carry an extra wrap bit so tail-head is the occupancy directly.
  logic [PW:0] r_head, r_tail;

  logic [CW-1:0]         w_count;
  logic                  w_empty, w_full;
  logic                  w_push, w_pop, w_ready;
  logic                  w_found, w_hit, w_conflict;
  logic [PW-1:0]         w_sel;
  logic [1:0]            w_lane;
  logic [DATA_WIDTH-1:0] w_sel_data, w_fwd;

  assign w_count = r_tail - r_head;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == CW'(SB_ENTRIES));
  assign w_lane  = sb.req_addr[1:0];

  // Youngest word match: walk oldest to youngest over live entries and let the
  // last hit win.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < SB_ENTRIES; k++) begin
      if ((CW'(k) < w_count) &&
          (r_addr[PW'(r_head[PW-1:0] + PW'(k))][ADDR_WIDTH-1:2] ==
           sb.req_addr[ADDR_WIDTH-1:2])) begin
        w_found = 1'b1;
        w_sel   = PW'(r_head[PW-1:0] + PW'(k));
      end
    end
  end

  assign w_sel_data = r_data[w_sel];

  // A word store covers any load to its word; a byte store only covers a byte
  // load to the same lane. Any other overlap is a conflict.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    if (w_found) begin
      if (!r_byte[w_sel]) begin
        w_hit = 1'b1;
        w_fwd = sb.req_size_byte
              ? {{(DATA_WIDTH-8){1'b0}}, w_sel_data[{w_lane, 3'b000} +: 8]}
              : w_sel_data;
      end else if (sb.req_size_byte && (r_addr[w_sel][1:0] == w_lane)) begin
        w_hit = 1'b1;
        w_fwd = {{(DATA_WIDTH-8){1'b0}}, w_sel_data[7:0]};
      end
    end
  end

  assign w_conflict = w_found & ~w_hit;
  assign w_ready    = (r_state == S_RUN) &
                      (sb.req_is_store ? ~w_full : ~w_conflict);
  assign w_push     = sb.req_valid & w_ready & sb.req_is_store;
  assign w_pop      = ~w_empty & sb.drain_ready;

  assign sb.req_ready       = w_ready;
  assign sb.fwd_hit         = sb.req_valid & ~sb.req_is_store & w_hit & (r_state == S_RUN);
  assign sb.fwd_data        = sb.fwd_hit ? w_fwd : '0;
  assign sb.drain_valid     = ~w_empty;
  assign sb.drain_addr      = r_addr[r_head[PW-1:0]];
  assign sb.drain_data      = r_data[r_head[PW-1:0]];
  assign sb.drain_size_byte = r_byte[r_head[PW-1:0]];
  assign sb.fence_done      = (r_state == S_DONE);
  assign sb.sb_count        = w_count;
  assign sb.sb_empty        = w_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + CW'(1);
      if (w_pop)  r_head <= r_head + CW'(1);
    end
  end

  // Payload storage needs no reset: occupancy alone decides which entries live.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr[r_tail[PW-1:0]] <= sb.req_addr;
      r_data[r_tail[PW-1:0]] <= sb.req_data;
      r_byte[r_tail[PW-1:0]] <= sb.req_size_byte;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (sb.fence_req) w_state_nxt = S_FENCE;
      // Finish on the edge that pops the last entry, not one cycle later.
      S_FENCE: if (w_empty || ((w_count == CW'(1)) && w_pop)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end
endmodule

// File: tb/tb_store_buffer_stage.sv
module tb_store_buffer_stage;
  logic clock, reset;
  int   total, bad, npop;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        sz;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic        st;
    logic        sz;
    logic [31:0] a;
    logic [31:0] d;
    logic        rdy;
    logic        hit;
    logic [31:0] fwd;
  } vec_t;
  vec_t tv[13];

  store_buffer_stage_if #(.SB_ENTRIES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) sb_if();

  store_buffer_stage #(.SB_ENTRIES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .sb(sb_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock: scoreboard work at the negedge, then return just after posedge.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (reset) begin
      if (sb_if.drain_valid && sb_if.drain_ready) begin
        if (q.size() == 0) chk("drain_unexpected", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          npop++;
          chk("drain_addr", sb_if.drain_addr, e.addr);
          chk("drain_size", 32'(sb_if.drain_size_byte), 32'(e.sz));
          chk("drain_data", e.sz ? {24'b0, sb_if.drain_data[7:0]} : sb_if.drain_data,
                            e.sz ? {24'b0, e.data[7:0]} : e.data);
        end
      end
      if (sb_if.req_valid && sb_if.req_is_store && sb_if.req_ready)
        q.push_back('{addr: sb_if.req_addr, data: sb_if.req_data, sz: sb_if.req_size_byte});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    sb_if.req_valid     = 1'b0;
    sb_if.req_is_store  = 1'b0;
    sb_if.req_size_byte = 1'b0;
    sb_if.req_addr      = '0;
    sb_if.req_data      = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic sz,
                       input logic exp_rdy, input string nm);
    sb_if.req_valid     = 1'b1;
    sb_if.req_is_store  = 1'b1;
    sb_if.req_size_byte = sz;
    sb_if.req_addr      = a;
    sb_if.req_data      = d;
    #1;
    chk(nm, 32'(sb_if.req_ready), 32'(exp_rdy));
    tick();
    idle();
  endtask

  task automatic drain_all(input string nm);
    sb_if.drain_ready = 1'b1;
    for (int i = 0; i < 40 && !sb_if.sb_empty; i++) tick();
    chk(nm, 32'(sb_if.sb_empty), 32'd1);
    sb_if.drain_ready = 1'b0;
  endtask

  initial begin
    int cyc, acc, p0;
    total = 0; bad = 0; npop = 0;

    //      st  sz  addr        data          rdy hit fwd
    tv[0]  = '{1'b0, 1'b1, 32'h103, 32'h0,        1'b1, 1'b1, 32'h000000DE};
    tv[1]  = '{1'b0, 1'b0, 32'h100, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
    tv[2]  = '{1'b0, 1'b1, 32'h100, 32'h0,        1'b1, 1'b1, 32'h000000EF};
    tv[3]  = '{1'b0, 1'b1, 32'h101, 32'h0,        1'b1, 1'b1, 32'h000000BE};
    tv[4]  = '{1'b0, 1'b0, 32'h104, 32'h0,        1'b1, 1'b0, 32'h0};
    tv[5]  = '{1'b0, 1'b1, 32'h200, 32'h0,        1'b1, 1'b0, 32'h0};
    tv[6]  = '{1'b1, 1'b1, 32'h101, 32'h00000055, 1'b1, 1'b0, 32'h0};
    tv[7]  = '{1'b0, 1'b0, 32'h100, 32'h0,        1'b0, 1'b0, 32'h0};
    tv[8]  = '{1'b0, 1'b1, 32'h101, 32'h0,        1'b1, 1'b1, 32'h00000055};
    tv[9]  = '{1'b0, 1'b1, 32'h102, 32'h0,        1'b0, 1'b0, 32'h0};
    tv[10] = '{1'b0, 1'b1, 32'h103, 32'h0,        1'b0, 1'b0, 32'h0};
    tv[11] = '{1'b1, 1'b0, 32'h104, 32'h12345678, 1'b1, 1'b0, 32'h0};
    tv[12] = '{1'b0, 1'b1, 32'h106, 32'h0,        1'b1, 1'b1, 32'h00000034};

    reset = 1'b0;
    idle();
    sb_if.drain_ready = 1'b0;
    sb_if.fence_req   = 1'b0;
    #3;
    chk("rst_drain_valid", 32'(sb_if.drain_valid), 32'd0);
    chk("rst_fence_done",  32'(sb_if.fence_done),  32'd0);
    chk("rst_fwd_hit",     32'(sb_if.fwd_hit),     32'd0);
    chk("rst_sb_empty",    32'(sb_if.sb_empty),    32'd1);
    chk("rst_sb_count",    32'(sb_if.sb_count),    32'd0);
    chk("rst_req_ready",   32'(sb_if.req_ready),   32'd1);
    @(posedge clock); #1;
    reset = 1'b1;

    // T1: async reset discards entries without waiting for an edge.
    for (int i = 0; i < 3; i++) store(32'h40 + 32'(4*i), 32'hA0 + 32'(i), 1'b0, 1'b1, "t1_push");
    chk("t1_count3", 32'(sb_if.sb_count), 32'd3);
    reset = 1'b0;
    #1;
    chk("t1_async_drain_valid", 32'(sb_if.drain_valid), 32'd0);
    chk("t1_async_count",       32'(sb_if.sb_count),    32'd0);
    q.delete();
    tick();
    reset = 1'b1;

    // T2: fill to full, store blocked, unrelated load passes.
    for (int i = 0; i < 4; i++) store(32'h100 + 32'(4*i), 32'h1000 + 32'(i), 1'b0, 1'b1, "t2_push");
    chk("t2_count4", 32'(sb_if.sb_count), 32'd4);
    sb_if.req_valid = 1'b1; sb_if.req_is_store = 1'b1; sb_if.req_addr = 32'h110; sb_if.req_data = 32'h5;
    #1;
    chk("t2_full_ready", 32'(sb_if.req_ready), 32'd0);
    tick();
    sb_if.req_is_store = 1'b0; sb_if.req_addr = 32'h200;
    #1;
    chk("t2_load_ready", 32'(sb_if.req_ready), 32'd1);
    chk("t2_load_hit",   32'(sb_if.fwd_hit),   32'd0);
    chk("t2_count_held", 32'(sb_if.sb_count),  32'd4);
    idle();
    drain_all("t2_drained");

    // T3: forwarding table.
    store(32'h100, 32'hDEADBEEF, 1'b0, 1'b1, "t3_push");
    for (int i = 0; i < 13; i++) begin
      sb_if.req_valid     = 1'b1;
      sb_if.req_is_store  = tv[i].st;
      sb_if.req_size_byte = tv[i].sz;
      sb_if.req_addr      = tv[i].a;
      sb_if.req_data      = tv[i].d;
      #1;
      chk($sformatf("t3_ready[%0d]", i), 32'(sb_if.req_ready), 32'(tv[i].rdy));
      chk($sformatf("t3_hit[%0d]", i),   32'(sb_if.fwd_hit),   32'(tv[i].hit));
      if (tv[i].hit) chk($sformatf("t3_fwd[%0d]", i), sb_if.fwd_data, tv[i].fwd);
      tick();
      idle();
    end
    // Conflicting word load stays stalled until the byte store pops.
    sb_if.req_valid = 1'b1; sb_if.req_is_store = 1'b0; sb_if.req_size_byte = 1'b0;
    sb_if.req_addr  = 32'h100;
    sb_if.drain_ready = 1'b1;
    #1;
    chk("t3_conflict_hold", 32'(sb_if.req_ready), 32'd0);
    cyc = 0;
    while (cyc < 10 && !sb_if.req_ready) begin tick(); cyc++; end
    chk("t3_conflict_cycles", 32'(cyc), 32'd2);
    chk("t3_conflict_count",  32'(sb_if.sb_count), 32'd1);
    chk("t3_after_hit",       32'(sb_if.fwd_hit),  32'd0);
    idle();
    drain_all("t3_drained");

    // T4: simultaneous push and pop keeps the count.
    store(32'h200, 32'h11111111, 1'b0, 1'b1, "t4_push");
    store(32'h204, 32'h22222222, 1'b0, 1'b1, "t4_push");
    chk("t4_count2", 32'(sb_if.sb_count), 32'd2);
    sb_if.drain_ready = 1'b1;
    store(32'h208, 32'h33333333, 1'b0, 1'b1, "t4_push_pop");
    chk("t4_count_same", 32'(sb_if.sb_count), 32'd2);
    drain_all("t4_drained");

    // T5: 10 stores with random drain backpressure (pointer wrap).
    p0 = npop; acc = 0;
    for (int c = 0; c < 300 && acc < 10; c++) begin
      sb_if.req_valid     = 1'b1;
      sb_if.req_is_store  = 1'b1;
      sb_if.req_size_byte = 1'($urandom_range(0, 1));
      sb_if.req_addr      = 32'h300 + 32'(4*acc);
      sb_if.req_data      = $urandom;
      sb_if.drain_ready   = 1'($urandom_range(0, 1));
      #1;
      chk("t5_count_le4", 32'(sb_if.sb_count <= 3'd4), 32'd1);
      if (sb_if.req_ready) acc++;
      tick();
    end
    idle();
    chk("t5_accepted", 32'(acc), 32'd10);
    drain_all("t5_drained");
    chk("t5_popped", 32'(npop - p0), 32'd10);

    // T6: fence with three entries.
    for (int i = 0; i < 3; i++) store(32'h400 + 32'(4*i), 32'h600 + 32'(i), 1'b0, 1'b1, "t6_push");
    sb_if.fence_req = 1'b1;
    tick();
    sb_if.fence_req = 1'b0;
    sb_if.req_valid = 1'b1; sb_if.req_is_store = 1'b1; sb_if.req_addr = 32'h500;
    #1;
    chk("t6_fence_ready", 32'(sb_if.req_ready),  32'd0);
    chk("t6_fence_early", 32'(sb_if.fence_done), 32'd0);
    sb_if.drain_ready = 1'b1;
    cyc = 0;
    while (cyc < 20 && !sb_if.fence_done) begin tick(); cyc++; end
    chk("t6_done_seen",   32'(sb_if.fence_done), 32'd1);
    chk("t6_done_cycles", 32'(cyc),              32'd3);
    chk("t6_done_empty",  32'(sb_if.sb_empty),   32'd1);
    chk("t6_done_ready",  32'(sb_if.req_ready),  32'd0);
    tick();
    chk("t6_done_pulse",  32'(sb_if.fence_done), 32'd0);
    chk("t6_run_ready",   32'(sb_if.req_ready),  32'd1);
    chk("t6_no_push",     32'(sb_if.sb_count),   32'd0);
    idle();

    // Fence while empty: RUN -> FENCE -> DONE.
    sb_if.fence_req = 1'b1;
    tick();
    sb_if.fence_req = 1'b0;
    chk("fe_fence_done0", 32'(sb_if.fence_done), 32'd0);
    chk("fe_fence_ready", 32'(sb_if.req_ready),  32'd0);
    tick();
    chk("fe_done1",       32'(sb_if.fence_done), 32'd1);
    tick();
    chk("fe_done_clear",  32'(sb_if.fence_done), 32'd0);
    chk("fe_run_ready",   32'(sb_if.req_ready),  32'd1);

    chk("sb_queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
